vote_capture: RTL and testbench
===============================

Name: vote_capture

Overview:
- Upstream stage of the 3-digit 7-segment vote display.
- Accepts raw push-button votes and debounces them; a poll-control FSM enforces one authorized vote per voter.
- Keeps one saturating binary tally per candidate and drives the selected candidate's 10-bit count to the binary-to-digit / 7-segment display stage.

Parameters:
- NUM_CAND, 3, number of candidates / vote buttons (1..4).
- CNT_W, 10, width of each tally register.
- MAX_COUNT, 999, saturation value of a tally (largest 3-digit displayable value).
- DEBOUNCE_CYCLES, 4, consecutive stable-high samples needed before a press is recognized.
- LOCK_CYCLES, 8, lockout length after an accepted vote.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- open_poll  in  1  level/pulse; opens the poll.
- close_poll  in  1  level/pulse; closes the poll permanently until reset.
- auth  in  1  officer authorizes exactly one voter.
- vote_btn  in  NUM_CAND  raw asynchronous candidate buttons.
- disp_sel  in  2  candidate index whose tally drives count.
- count  out  CNT_W  tally of candidate disp_sel; 0 if disp_sel >= NUM_CAND.
- total  out  CNT_W+2  sum of all tallies.
- ready  out  1  high in ARMED (voter may press).
- accepted  out  1  one-cycle pulse, vote registered.
- rejected  out  1  one-cycle pulse, multi-button press discarded.
- sat  out  1  sticky, some tally hit MAX_COUNT and a further vote arrived.
- poll_state  out  3  encoded FSM state.

Behaviour:
- Reset values:
  - All tallies and total are 0; count is 0.
  - ready, accepted, rejected and sat are 0.
  - State is IDLE.
  - Debouncers are cleared.
- Input path:
  - Each vote_btn bit passes through a 2-flop synchronizer, then a stable counter.
  - Pulse press[i] is high for exactly one cycle when the synced input has been high for DEBOUNCE_CYCLES consecutive cycles.
  - No further pulse until the input has been low for at least one synced sample.
  - Latency: a held raw press produces press[i] DEBOUNCE_CYCLES+2 cycles after it is first sampled high.
- FSM states:
  - IDLE (0): open_poll -> WAIT_AUTH.
  - WAIT_AUTH (1): auth -> ARMED. Presses are ignored and counted nowhere.
  - ARMED (2): ready=1.
    - Exactly one press bit set -> increment that tally, go to LOCK.
    - Two or more bits set in the same cycle -> rejected pulse, stay ARMED.
  - LOCK (3): down-counter loaded with LOCK_CYCLES-1; when it expires -> WAIT_AUTH. Presses are ignored.
  - CLOSED (4): tallies frozen; only reset exits.
- Global transition: close_poll in any state except IDLE -> CLOSED next cycle. close_poll beats open_poll, auth and press in the same cycle, and a simultaneous vote is not counted.
- auth outside WAIT_AUTH is ignored and is not remembered.
- Timing of an accepted vote:
  - Tally, total and state update at the edge where ARMED sees a valid press.
  - accepted is registered and is high during the first LOCK cycle, aligned with the updated count.
- Saturation:
  - A tally at MAX_COUNT does not increment and total does not change.
  - sat sets and stays set until reset.
  - The vote still consumes the authorization: accepted pulses and the FSM goes to LOCK.
- Width: total is wide enough for NUM_CAND*MAX_COUNT and never wraps. count is a combinational mux of the registered tallies.
- disp_sel may change at any time; count follows it in the same cycle.
- reset mid-operation (any state, in lockout, during debounce) returns everything to the reset values on that edge.

Decomposition:
- Shared package (vote_pkg):
  - State encodings IDLE..CLOSED.
  - Default constants: MAX_COUNT=999, CNT_W=10.
- Sub-module vote_debounce:
  - One instance per button.
  - Contains the synchronizer, stable counter and rising pulse.
  - Parameter DEBOUNCE_CYCLES.

Test Plan:
- Reset, open_poll, auth, then hold vote_btn[1] 10 cycles -> press at +6 cycles; tally1=1, total=1, accepted 1 cycle; state goes LOCK for 8 cycles, then WAIT_AUTH.
- Press in WAIT_AUTH (no auth) and during LOCK -> all tallies unchanged, no accepted.
- In ARMED, vote_btn=3'b011 rising together -> rejected pulse, tallies 0, ready still 1; then single press of bit2 -> tally2=1.
- Preload tally0 to 999 via 999 authorized votes, then one more -> tally0=999, sat=1, accepted=1, total=999.
- close_poll asserted in the same cycle as a valid press in ARMED -> state CLOSED, tally unchanged; later open_poll/auth ignored.
- disp_sel=3 with NUM_CAND=3 -> count=0; synchronous reset asserted during LOCK -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared definitions for the vote capture front end: poll FSM state encodings
// and default tally sizing.
package vote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_AUTH = 3'd1,
    ST_ARMED     = 3'd2,
    ST_LOCK      = 3'd3,
    ST_CLOSED    = 3'd4
  } poll_state_e;

  localparam int DEF_CNT_W     = 10;
  localparam int DEF_MAX_COUNT = 999;

endpackage

// File: rtl/vote_debounce.sv
// One vote button: 2-flop synchronizer, stable-high counter and a single
// press pulse per continuous high period.
module vote_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int STABLE_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic                sync1_q, sync2_q;
  logic [STABLE_W-1:0] stable_q, stable_d;
  logic                fired_q, fired_d;
  logic                press_q, press_d;

  // The counter saturates at DEBOUNCE_CYCLES; fired blocks re-triggering
  // until the synced input has dropped low at least once.
  always_comb begin
    stable_d = stable_q;
    fired_d  = fired_q;
    press_d  = 1'b0;
    if (!sync2_q) begin
      stable_d = '0;
      fired_d  = 1'b0;
    end else if (stable_q != STABLE_W'(DEBOUNCE_CYCLES)) begin
      stable_d = stable_q + 1'b1;
    end else if (!fired_q) begin
      press_d = 1'b1;
      fired_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= '0;
      fired_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      fired_q  <= fired_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/vote_capture.sv
// Vote capture front end: debounces candidate buttons, runs the poll-control
// FSM and keeps one saturating tally per candidate for the display stage.
module vote_capture
  import vote_pkg::*;
#(
  parameter int NUM_CAND        = 3,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int MAX_COUNT       = DEF_MAX_COUNT,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCK_CYCLES     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                open_poll,
  input  logic                close_poll,
  input  logic                auth,
  input  logic [NUM_CAND-1:0] vote_btn,
  input  logic [1:0]          disp_sel,
  output logic [CNT_W-1:0]    count,
  output logic [CNT_W+1:0]    total,
  output logic                ready,
  output logic                accepted,
  output logic                rejected,
  output logic                sat,
  output logic [2:0]          poll_state
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [NUM_CAND-1:0] press;
  logic [1:0]          pressIdx;
  logic [2:0]          pressCnt;

  poll_state_e         state_q, state_d;
  logic [LOCK_W-1:0]   lockCnt_q, lockCnt_d;
  logic [CNT_W-1:0]    tally_q [NUM_CAND];
  logic [CNT_W-1:0]    tally_d [NUM_CAND];
  logic [CNT_W+1:0]    total_q, total_d;
  logic                accepted_q, accepted_d;
  logic                rejected_q, rejected_d;
  logic                sat_q, sat_d;

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_deb
    vote_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (vote_btn[g]),
      .press_o(press[g])
    );
  end

  // Number of simultaneous presses and the index of the (single) one.
  always_comb begin
    pressIdx = '0;
    pressCnt = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (press[i]) begin
        pressIdx = 2'(i);
        pressCnt = pressCnt + 3'd1;
      end
    end
  end

  // close_poll outranks every other event, including a press seen in ARMED.
  always_comb begin
    state_d    = state_q;
    lockCnt_d  = lockCnt_q;
    tally_d    = tally_q;
    total_d    = total_q;
    accepted_d = 1'b0;
    rejected_d = 1'b0;
    sat_d      = sat_q;
    if (close_poll && state_q != ST_IDLE) begin
      state_d = ST_CLOSED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (open_poll) state_d = ST_WAIT_AUTH;
        end
        ST_WAIT_AUTH: begin
          if (auth) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (pressCnt == 3'd1) begin
            accepted_d = 1'b1;
            state_d    = ST_LOCK;
            lockCnt_d  = LOCK_W'(LOCK_CYCLES - 1);
            if (tally_q[pressIdx] == CNT_W'(MAX_COUNT)) begin
              sat_d = 1'b1;
            end else begin
              tally_d[pressIdx] = tally_q[pressIdx] + 1'b1;
              total_d           = total_q + 1'b1;
            end
          end else if (pressCnt > 3'd1) begin
            rejected_d = 1'b1;
          end
        end
        ST_LOCK: begin
          if (lockCnt_q == '0) state_d = ST_WAIT_AUTH;
          else lockCnt_d = lockCnt_q - 1'b1;
        end
        ST_CLOSED: begin
          state_d = ST_CLOSED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lockCnt_q  <= '0;
      total_q    <= '0;
      accepted_q <= 1'b0;
      rejected_q <= 1'b0;
      sat_q      <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      lockCnt_q  <= lockCnt_d;
      total_q    <= total_d;
      accepted_q <= accepted_d;
      rejected_q <= rejected_d;
      sat_q      <= sat_d;
      tally_q    <= tally_d;
    end
  end

  // Out-of-range selections fall through to zero.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (disp_sel == 2'(i)) count = tally_q[i];
    end
  end

  assign total      = total_q;
  assign ready      = (state_q == ST_ARMED);
  assign accepted   = accepted_q;
  assign rejected   = rejected_q;
  assign sat        = sat_q;
  assign poll_state = state_q;

endmodule

// File: tb/tb_vote_capture.sv
// Self-checking bench for vote_capture: directed poll scenarios plus a random
// phase, all checked every cycle against a behavioural model of the rules.
module tb_vote_capture;

  localparam int NUM_CAND        = 3;
  localparam int CNT_W           = 10;
  localparam int MAX_COUNT       = 999;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int LOCK_CYCLES     = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                openPoll = 1'b0;
  logic                closePoll = 1'b0;
  logic                auth = 1'b0;
  logic [NUM_CAND-1:0] voteBtn = '0;
  logic [1:0]          dispSel = '0;
  logic [CNT_W-1:0]    count;
  logic [CNT_W+1:0]    total;
  logic                ready;
  logic                accepted;
  logic                rejected;
  logic                sat;
  logic [2:0]          pollState;

  int vectors = 0;
  int miscompares = 0;
  int cycleNum = 0;

  // Model state: run lengths of raw high samples (two edges of delay mirror
  // the synchronizer), the press vector in flight, and the poll rules.
  int run1 [NUM_CAND];
  int run2 [NUM_CAND];
  bit pressNow [NUM_CAND];
  int tallyM [NUM_CAND];
  int stateM = 0;
  int lockLeft = 0;
  bit accM = 1'b0;
  bit rejM = 1'b0;
  bit satM = 1'b0;
  bit modelValid = 1'b0;

  vote_capture #(
    .NUM_CAND       (NUM_CAND),
    .CNT_W          (CNT_W),
    .MAX_COUNT      (MAX_COUNT),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LOCK_CYCLES    (LOCK_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .open_poll (openPoll),
    .close_poll(closePoll),
    .auth      (auth),
    .vote_btn  (voteBtn),
    .disp_sel  (dispSel),
    .count     (count),
    .total     (total),
    .ready     (ready),
    .accepted  (accepted),
    .rejected  (rejected),
    .sat       (sat),
    .poll_state(pollState)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleNum, got, exp);
    end
  endtask

  task automatic applyStimulus(input int rst, input int op, input int cl, input int au,
                               input int btn, input int sel);
    @(negedge clk);
    reset     = (rst != 0);
    openPoll  = (op != 0);
    closePoll = (cl != 0);
    auth      = (au != 0);
    voteBtn   = NUM_CAND'(btn);
    dispSel   = 2'(sel);
  endtask

  // Authorize (optionally), press candidate idx and wait for the accept pulse.
  task automatic castVote(input int idx, input bit needAuth);
    int k;
    if (needAuth) begin
      k = 0;
      while (pollState != 3'd1 && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      checkOutput("vote_wait_auth", int'(pollState), 1);
      applyStimulus(0, 0, 0, 1, 0, int'(dispSel));
    end
    applyStimulus(0, 0, 0, 0, 1 << idx, int'(dispSel));
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!accepted && k < 20);
    checkOutput("vote_accepted", int'(accepted), 1);
    applyStimulus(0, 0, 0, 0, 0, int'(dispSel));
  endtask

  // Behavioural model, advanced on every rising edge.
  initial begin
    int nPress;
    int who;
    bit newP;
    forever begin
      @(posedge clk);
      cycleNum++;
      if (reset) begin
        for (int i = 0; i < NUM_CAND; i++) begin
          run1[i] = 0; run2[i] = 0; pressNow[i] = 1'b0; tallyM[i] = 0;
        end
        stateM = 0; lockLeft = 0; accM = 1'b0; rejM = 1'b0; satM = 1'b0;
        modelValid = 1'b1;
      end else begin
        nPress = 0;
        who = 0;
        for (int i = 0; i < NUM_CAND; i++) begin
          if (pressNow[i]) begin nPress++; who = i; end
        end
        accM = 1'b0;
        rejM = 1'b0;
        if (closePoll && stateM != 0) begin
          stateM = 4;
        end else begin
          case (stateM)
            0: if (openPoll) stateM = 1;
            1: if (auth) stateM = 2;
            2: begin
              if (nPress == 1) begin
                accM = 1'b1;
                if (tallyM[who] >= MAX_COUNT) satM = 1'b1;
                else tallyM[who] = tallyM[who] + 1;
                stateM = 3;
                lockLeft = LOCK_CYCLES;
              end else if (nPress > 1) begin
                rejM = 1'b1;
              end
            end
            3: begin
              lockLeft--;
              if (lockLeft == 0) stateM = 1;
            end
            default: ;
          endcase
        end
        for (int i = 0; i < NUM_CAND; i++) begin
          newP = (run2[i] == DEBOUNCE_CYCLES + 1);
          run2[i] = run1[i];
          if (voteBtn[i]) run1[i] = (run1[i] >= DEBOUNCE_CYCLES + 2) ? DEBOUNCE_CYCLES + 2 : run1[i] + 1;
          else run1[i] = 0;
          pressNow[i] = newP;
        end
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    int expCount;
    int expTotal;
    forever begin
      @(posedge clk); #1;
      if (modelValid) begin
        expTotal = 0;
        for (int i = 0; i < NUM_CAND; i++) expTotal += tallyM[i];
        expCount = 0;
        if (int'(dispSel) < NUM_CAND) expCount = tallyM[dispSel];
        checkOutput("count", int'(count), expCount);
        checkOutput("total", int'(total), expTotal);
        checkOutput("ready", int'(ready), (stateM == 2) ? 1 : 0);
        checkOutput("accepted", int'(accepted), int'(accM));
        checkOutput("rejected", int'(rejected), int'(rejM));
        checkOutput("sat", int'(sat), int'(satM));
        checkOutput("poll_state", int'(pollState), stateM);
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleNum);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int edges;
    int lockLen;
    int k;
    repeat (2) @(posedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("reset_total", int'(total), 0);
    checkOutput("reset_state", int'(pollState), 0);

    // Single authorized vote for candidate 1, then the lockout.
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 3'b010, 1);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!accepted && edges < 30);
    checkOutput("d1_accept_latency", edges, 8);
    checkOutput("d1_tally1", int'(count), 1);
    checkOutput("d1_total", int'(total), 1);
    checkOutput("d1_state_lock", int'(pollState), 3);
    lockLen = 0;
    while (pollState == 3'd3 && lockLen < 40) begin
      lockLen++;
      @(posedge clk); #1;
    end
    checkOutput("d1_lock_len", lockLen, 8);
    checkOutput("d1_back_wait_auth", int'(pollState), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Presses without authorization and during lockout are ignored.
    applyStimulus(0, 0, 0, 0, 3'b001, 1);
    repeat (10) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    checkOutput("d2_no_auth_total", int'(total), 1);
    checkOutput("d2_still_wait", int'(pollState), 1);
    castVote(1, 1);
    applyStimulus(0, 0, 0, 0, 3'b100, 2);
    repeat (12) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 2);
    repeat (3) @(negedge clk);
    checkOutput("d2_lock_press_total", int'(total), 2);
    checkOutput("d2_lock_press_tally2", int'(count), 0);

    // Two buttons rising together are rejected; a single press then counts.
    applyStimulus(0, 0, 0, 1, 0, 2);
    applyStimulus(0, 0, 0, 0, 3'b011, 2);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!rejected && k < 20);
    checkOutput("d3_rejected", int'(rejected), 1);
    checkOutput("d3_ready_after_reject", int'(ready), 1);
    checkOutput("d3_total_after_reject", int'(total), 2);
    applyStimulus(0, 0, 0, 0, 0, 2);
    repeat (2) @(negedge clk);
    castVote(2, 0);
    checkOutput("d3_tally2", int'(count), 1);
    checkOutput("d3_total", int'(total), 3);

    // close_poll in the same cycle ARMED sees a valid press.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 3'b001, 0);
    repeat (6) @(negedge clk);
    applyStimulus(0, 0, 1, 0, 3'b001, 0);
    applyStimulus(0, 0, 0, 0, 3'b001, 0);
    checkOutput("d5_closed", int'(pollState), 4);
    checkOutput("d5_no_accept", int'(accepted), 0);
    checkOutput("d5_tally0", int'(count), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 3'b010, 0);
    repeat (10) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("d5_still_closed", int'(pollState), 4);
    checkOutput("d5_total", int'(total), 0);

    // Fill candidate 0 to the limit, then one more vote saturates.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int v = 0; v < MAX_COUNT; v++) castVote(0, 1);
    checkOutput("d4_sat_before", int'(sat), 0);
    checkOutput("d4_count_full", int'(count), 999);
    castVote(0, 1);
    checkOutput("d4_sat", int'(sat), 1);
    checkOutput("d4_total", int'(total), 999);
    checkOutput("d4_count", int'(count), 999);
    applyStimulus(0, 0, 0, 0, 0, 3);
    #1;
    checkOutput("d6_count_oob", int'(count), 0);
    checkOutput("d6_in_lock", int'(pollState), 3);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("d6_reset_count", int'(count), 0);
    checkOutput("d6_reset_total", int'(total), 0);
    checkOutput("d6_reset_state", int'(pollState), 0);
    checkOutput("d6_reset_sat", int'(sat), 0);

    // Random traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      int rb;
      rb = int'(voteBtn);
      if ($urandom_range(0, 29) == 0) begin
        rb = int'($urandom_range(0, 7));
      end else begin
        for (int i = 0; i < NUM_CAND; i++) begin
          if ($urandom_range(0, 6) == 0) rb = rb ^ (1 << i);
        end
      end
      applyStimulus(($urandom_range(0, 399) == 0) ? 1 : 0,
                    ($urandom_range(0, 19) == 0) ? 1 : 0,
                    ($urandom_range(0, 599) == 0) ? 1 : 0,
                    ($urandom_range(0, 5) == 0) ? 1 : 0,
                    rb, int'($urandom_range(0, 3)));
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
